// File: rtl/alu_pkg.sv
// Shared opcodes, operand-select codes and FSM state encoding for the execute-stage ALU.
package alu_pkg;

    localparam int unsigned ALU_FUN_W = 4;

    localparam logic [ALU_FUN_W-1:0] ALU_ADD  = 4'h0;
    localparam logic [ALU_FUN_W-1:0] ALU_SLL  = 4'h1;
    localparam logic [ALU_FUN_W-1:0] ALU_SLT  = 4'h2;
    localparam logic [ALU_FUN_W-1:0] ALU_SLTU = 4'h3;
    localparam logic [ALU_FUN_W-1:0] ALU_XOR  = 4'h4;
    localparam logic [ALU_FUN_W-1:0] ALU_SRL  = 4'h5;
    localparam logic [ALU_FUN_W-1:0] ALU_OR   = 4'h6;
    localparam logic [ALU_FUN_W-1:0] ALU_AND  = 4'h7;
    localparam logic [ALU_FUN_W-1:0] ALU_SUB  = 4'h8;
    localparam logic [ALU_FUN_W-1:0] ALU_MUL  = 4'h9;
    localparam logic [ALU_FUN_W-1:0] ALU_SRA  = 4'hD;

    localparam logic OP2_RS2 = 1'b0;
    localparam logic OP2_IMM = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_HOLD = 2'd2
    } alu_state_e;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one partial-product bit per cycle, XLEN cycles, low XLEN bits kept.
module alu_mul_iter #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            done,
    output logic [XLEN-1:0] prod
);

    localparam int unsigned CNT_W = $clog2(XLEN);

    logic             busy;
    logic [CNT_W-1:0] count;
    logic [XLEN-1:0]  mcand;
    logic [XLEN-1:0]  mplier;
    logic [XLEN-1:0]  acc;

    // Bit 0 is folded in on the start edge so the last bit lands XLEN-1 edges later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy   <= 1'b0;
            done   <= 1'b0;
            count  <= '0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
        end else begin
            done <= 1'b0;
            if (start) begin
                busy   <= 1'b1;
                count  <= CNT_W'(1);
                acc    <= b[0] ? a : '0;
                mcand  <= a << 1;
                mplier <= b >> 1;
            end else if (busy) begin
                if (mplier[0]) begin
                    acc <= acc + mcand;
                end
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                count  <= count + CNT_W'(1);
                if (count == CNT_W'(XLEN - 1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

    assign prod = acc;

endmodule

// File: rtl/alu_pipe.sv
// Registered execute-stage ALU with valid/ready on both sides.
// Define ALU_MUL_EN to add the iterative MUL (opcode 9); otherwise opcode 9 is illegal.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned SHAMT_W = $clog2(XLEN)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [ALU_FUN_W-1:0] alufun,
    input  logic                 op2sel,
    input  logic [XLEN-1:0]      rs1_val,
    input  logic [XLEN-1:0]      rs2_val,
    input  logic [XLEN-1:0]      imm,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [XLEN-1:0]      result,
    output logic                 illegal
);

    alu_state_e         state;
    alu_state_e         state_nxt;
    logic               accept;
    logic               load_alu;
    logic [XLEN-1:0]    op_b;
    logic [SHAMT_W-1:0] shamt;
    logic [XLEN-1:0]    alu_res_c;
    logic               illegal_c;
`ifdef ALU_MUL_EN
    logic               mul_start;
    logic               load_mul;
    logic               mul_done;
    logic [XLEN-1:0]    mul_prod;
`endif

    assign op_b     = (op2sel == OP2_IMM) ? imm : rs2_val;
    assign shamt    = op_b[SHAMT_W-1:0];
    assign in_ready = (state == ST_IDLE) || ((state == ST_HOLD) && out_ready);
    assign accept   = in_valid && in_ready;

    // Single-cycle result mux; MUL is handled by the iterative unit.
    always_comb begin
        alu_res_c = '0;
        illegal_c = 1'b0;
        case (alufun)
            ALU_ADD:  alu_res_c = rs1_val + op_b;
            ALU_SUB:  alu_res_c = rs1_val - op_b;
            ALU_SLL:  alu_res_c = rs1_val << shamt;
            ALU_SLT:  alu_res_c = XLEN'($signed(rs1_val) < $signed(op_b));
            ALU_SLTU: alu_res_c = XLEN'(rs1_val < op_b);
            ALU_XOR:  alu_res_c = rs1_val ^ op_b;
            ALU_SRL:  alu_res_c = rs1_val >> shamt;
            ALU_SRA:  alu_res_c = $unsigned($signed(rs1_val) >>> shamt);
            ALU_OR:   alu_res_c = rs1_val | op_b;
            ALU_AND:  alu_res_c = rs1_val & op_b;
            default:  illegal_c = 1'b1;
        endcase
    end

    // Next-state and load strobes; HOLD may hand straight over to a new op on the consuming edge.
    always_comb begin
        state_nxt = state;
        load_alu  = 1'b0;
`ifdef ALU_MUL_EN
        mul_start = 1'b0;
        load_mul  = 1'b0;
`endif
        case (state)
            ST_IDLE, ST_HOLD: begin
                if (accept) begin
`ifdef ALU_MUL_EN
                    if (alufun == ALU_MUL) begin
                        state_nxt = ST_BUSY;
                        mul_start = 1'b1;
                    end else
`endif
                    begin
                        state_nxt = ST_HOLD;
                        load_alu  = 1'b1;
                    end
                end else if ((state == ST_HOLD) && out_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
`ifdef ALU_MUL_EN
            ST_BUSY: begin
                if (mul_done) begin
                    state_nxt = ST_HOLD;
                    load_mul  = 1'b1;
                end
            end
`endif
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            result    <= '0;
            illegal   <= 1'b0;
        end else begin
            state     <= state_nxt;
            out_valid <= (state_nxt == ST_HOLD);
            if (load_alu) begin
                result  <= alu_res_c;
                illegal <= illegal_c;
            end
`ifdef ALU_MUL_EN
            else if (load_mul) begin
                result  <= mul_prod;
                illegal <= 1'b0;
            end
`endif
        end
    end

`ifdef ALU_MUL_EN
    alu_mul_iter #(
        .XLEN (XLEN)
    ) u_mul (
        .clk   (clk),
        .rst   (rst),
        .start (mul_start),
        .a     (rs1_val),
        .b     (op_b),
        .done  (mul_done),
        .prod  (mul_prod)
    );
`endif

endmodule
